// File: rtl/cpu_control.sv
// cpu_control: four-phase (Q1..Q4) instruction sequencer for a PIC10-compatible core.
// Owns PC, 2-level return stack, W, STATUS {Z,DC,C} and skip handling.
// Optional macro CPU_SLEEP_EN adds the SLEEP state and wake_in handling.
//
// state     | meaning
// FETCH     | Q1: prog_addr = PC, PC increments at the edge
// DECODE    | Q2: IR loads prog_data at the edge
// EXECUTE   | Q3: ALU sees IR, write strobes armed for Q4
// WRITEBACK | Q4: W/STATUS/PC/stack commit at the edge
// SLEEP     | halted until wake_in (CPU_SLEEP_EN only)
module cpu_control #(
  parameter int PC_WIDTH = 9
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [11:0]         prog_data,
  output logic [11:0]         alu_op_out,
  output logic [7:0]          alu_w_out,
  output logic                status_c_out,
  input  logic [7:0]          alu_result_in,
  input  logic [2:0]          alu_flags_in,
  input  logic                alu_c_load_in,
  input  logic                alu_dc_load_in,
  input  logic                alu_z_load_in,
  output logic [4:0]          rf_addr,
  output logic [7:0]          rf_wdata,
  output logic                rf_we,
  output logic                option_we,
  output logic [2:0]          tris_we,
  input  logic                wake_in,
  output logic                sleeping,
  output logic                instr_done
);

`ifdef CPU_SLEEP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, SLEEP} state_t;
`else
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
`endif

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q, stack0_q, stack1_q;
  logic [11:0]         ir_q;
  logic [7:0]          w_q;
  logic [2:0]          status_q;   // {Z, DC, C}
  logic                skip_q;

  logic       is_byte_d, is_movwf, is_clrw, is_clrf, is_bcf, is_bsf;
  logic       is_btfsc, is_btfss, is_fsz, is_retlw, is_call, is_goto, is_lit, is_option;
  logic       dest_file, dest_w, skip_cond;
  logic [2:0] tris_sel, status_next;

  // Instruction decode from the held IR
  always_comb begin
    is_byte_d = (ir_q[11:10] == 2'b00) && (ir_q[9:7] != 3'b000);
    is_movwf  = (ir_q[11:5] == 7'b0000001);
    is_clrw   = (ir_q[11:5] == 7'b0000010);
    is_clrf   = (ir_q[11:5] == 7'b0000011);
    is_bcf    = (ir_q[11:8] == 4'b0100);
    is_bsf    = (ir_q[11:8] == 4'b0101);
    is_btfsc  = (ir_q[11:8] == 4'b0110);
    is_btfss  = (ir_q[11:8] == 4'b0111);
    is_fsz    = (ir_q[11:6] == 6'b001011) || (ir_q[11:6] == 6'b001111);
    is_retlw  = (ir_q[11:8] == 4'b1000);
    is_call   = (ir_q[11:8] == 4'b1001);
    is_goto   = (ir_q[11:9] == 3'b101);
    is_lit    = (ir_q[11:10] == 2'b11) || is_retlw;
    is_option = (ir_q == 12'h002);
    tris_sel  = 3'b000;
    case (ir_q)
      12'h005: tris_sel = 3'b001;
      12'h006: tris_sel = 3'b010;
      12'h007: tris_sel = 3'b100;
      default: tris_sel = 3'b000;
    endcase
    dest_file = (is_byte_d && ir_q[5]) || is_movwf || is_clrf || is_bcf || is_bsf;
    dest_w    = (is_byte_d && !ir_q[5]) || is_clrw || is_lit;
    skip_cond = ((is_fsz || is_btfsc) && alu_flags_in[2]) || (is_btfss && !alu_flags_in[2]);
  end

  // STATUS update: direct file write first, strobe-loaded bits override it
  always_comb begin
    status_next = status_q;
    if (dest_file && (ir_q[4:0] == 5'h03)) status_next = alu_result_in[2:0];
    if (alu_c_load_in)  status_next[0] = alu_flags_in[0];
    if (alu_dc_load_in) status_next[1] = alu_flags_in[1];
    if (alu_z_load_in)  status_next[2] = alu_flags_in[2];
  end

  // Datapath outputs; the ALU only sees the opcode in Q3/Q4 of a non-skipped instruction
  always_comb begin
    alu_op_out = 12'h000;
    if (((state_q == EXECUTE) || (state_q == WRITEBACK)) && !skip_q) alu_op_out = ir_q;
  end

  assign prog_addr    = pc_q;
  assign alu_w_out    = w_q;
  assign status_c_out = status_q[0];
  assign rf_addr      = ir_q[4:0];
  assign rf_wdata     = alu_result_in;

`ifndef CPU_SLEEP_EN
  logic unused_wake;
  assign unused_wake = wake_in;
  assign sleeping    = 1'b0;
`endif

  // Sequencer: phase advance, registered Q4 strobes and all architectural commits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      stack0_q   <= '0;
      stack1_q   <= '0;
      ir_q       <= 12'h000;
      w_q        <= 8'h00;
      status_q   <= 3'b000;
      skip_q     <= 1'b0;
      rf_we      <= 1'b0;
      option_we  <= 1'b0;
      tris_we    <= 3'b000;
      instr_done <= 1'b0;
`ifdef CPU_SLEEP_EN
      sleeping   <= 1'b0;
`endif
    end else begin
      rf_we      <= 1'b0;
      option_we  <= 1'b0;
      tris_we    <= 3'b000;
      instr_done <= 1'b0;
      case (state_q)
        FETCH: begin
          pc_q    <= pc_q + PC_WIDTH'(1);
          state_q <= DECODE;
        end
        DECODE: begin
          ir_q    <= prog_data;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          // Strobes are raised for exactly the Q4 cycle
          state_q    <= WRITEBACK;
          instr_done <= 1'b1;
          if (!skip_q) begin
            rf_we     <= dest_file;
            option_we <= is_option;
            tris_we   <= tris_sel;
          end
        end
        WRITEBACK: begin
          state_q <= FETCH;
          if (skip_q) begin
            skip_q <= 1'b0;
          end else begin
            if (dest_w) w_q <= alu_result_in;
            status_q <= status_next;
            skip_q   <= skip_cond;
            if (is_goto) begin
              pc_q <= PC_WIDTH'(ir_q[8:0]);
            end else if (is_call) begin
              pc_q     <= PC_WIDTH'({1'b0, ir_q[7:0]});
              stack0_q <= pc_q;
              stack1_q <= stack0_q;
            end else if (is_retlw) begin
              pc_q     <= stack0_q;
              stack0_q <= stack1_q;
            end
`ifdef CPU_SLEEP_EN
            if (ir_q == 12'h003) begin
              state_q  <= SLEEP;
              sleeping <= 1'b1;
            end
`endif
          end
        end
`ifdef CPU_SLEEP_EN
        SLEEP: begin
          if (wake_in) begin
            state_q  <= FETCH;
            sleeping <= 1'b0;
          end
        end
`endif
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed and randomized checks of cpu_control against an
// instruction-level model (ROM, register file and ALU live in the bench).
module tb_cpu_control;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  prog_addr;
  logic [11:0] prog_data;
  logic [11:0] alu_op_out;
  logic [7:0]  alu_w_out;
  logic        status_c_out;
  logic [7:0]  alu_result_in;
  logic [2:0]  alu_flags_in;
  logic        alu_c_load_in, alu_dc_load_in, alu_z_load_in;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic        rf_we, option_we;
  logic [2:0]  tris_we;
  logic        wake_in = 1'b0;
  logic        sleeping, instr_done;

  cpu_control #(.PC_WIDTH(9)) dut (
    .clk(clk), .resetn(resetn), .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_op_out(alu_op_out), .alu_w_out(alu_w_out), .status_c_out(status_c_out),
    .alu_result_in(alu_result_in), .alu_flags_in(alu_flags_in),
    .alu_c_load_in(alu_c_load_in), .alu_dc_load_in(alu_dc_load_in), .alu_z_load_in(alu_z_load_in),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .option_we(option_we),
    .tris_we(tris_we), .wake_in(wake_in), .sleeping(sleeping), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [11:0] rom [512];
  logic [7:0]  file_mem [32];
  logic        file_clr = 1'b0;

  // Synchronous ROM with one-cycle latency
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Register file written by the DUT
  always @(posedge clk) begin
    if (file_clr) begin
      for (int i = 0; i < 32; i++) file_mem[i] <= 8'h00;
    end else if (rf_we) begin
      file_mem[rf_addr] <= rf_wdata;
    end
  end

  // Behavioural ALU: returns {z_ld, dc_ld, c_ld, Z, DC, C, result}
  function automatic logic [13:0] alu_ref(input logic [11:0] op, input logic [7:0] w,
                                          input logic [7:0] f, input logic cin);
    logic [7:0] res; logic z, dc, c, lz, ldc, lc; logic [8:0] s; logic [4:0] h;
    res = 8'h00; c = cin; dc = 1'b0; lz = 1'b0; ldc = 1'b0; lc = 1'b0;
    casez (op)
      12'b0000_001?_????: res = w;
      12'b0000_010?_????: begin res = 8'h00; lz = 1'b1; end
      12'b0000_011?_????: begin res = 8'h00; lz = 1'b1; end
      12'b0000_10??_????: begin
        s = {1'b0, f} + {1'b0, ~w} + 9'd1; h = {1'b0, f[3:0]} + {1'b0, ~w[3:0]} + 5'd1;
        res = s[7:0]; c = s[8]; dc = h[4]; lz = 1'b1; ldc = 1'b1; lc = 1'b1;
      end
      12'b0000_11??_????: begin res = f - 8'd1; lz = 1'b1; end
      12'b0001_00??_????: begin res = w | f; lz = 1'b1; end
      12'b0001_01??_????: begin res = w & f; lz = 1'b1; end
      12'b0001_10??_????: begin res = w ^ f; lz = 1'b1; end
      12'b0001_11??_????: begin
        s = {1'b0, f} + {1'b0, w}; h = {1'b0, f[3:0]} + {1'b0, w[3:0]};
        res = s[7:0]; c = s[8]; dc = h[4]; lz = 1'b1; ldc = 1'b1; lc = 1'b1;
      end
      12'b0010_00??_????: begin res = f; lz = 1'b1; end
      12'b0010_01??_????: begin res = ~f; lz = 1'b1; end
      12'b0010_10??_????: begin res = f + 8'd1; lz = 1'b1; end
      12'b0010_11??_????: res = f - 8'd1;
      12'b0011_00??_????: begin res = {cin, f[7:1]}; c = f[0]; lc = 1'b1; end
      12'b0011_01??_????: begin res = {f[6:0], cin}; c = f[7]; lc = 1'b1; end
      12'b0011_10??_????: res = {f[3:0], f[7:4]};
      12'b0011_11??_????: res = f + 8'd1;
      12'b0100_????_????: res = f & ~(8'h01 << op[7:5]);
      12'b0101_????_????: res = f | (8'h01 << op[7:5]);
      12'b011?_????_????: res = f;
      12'b1000_????_????: res = op[7:0];
      12'b1100_????_????: res = op[7:0];
      12'b1101_????_????: begin res = w | op[7:0]; lz = 1'b1; end
      12'b1110_????_????: begin res = w & op[7:0]; lz = 1'b1; end
      12'b1111_????_????: begin res = w ^ op[7:0]; lz = 1'b1; end
      default: res = 8'h00;
    endcase
    z = (res == 8'h00);
    if (op[11:9] == 3'b011) z = ~f[op[7:5]];
    return {lz, ldc, lc, z, dc, c, res};
  endfunction

  logic [13:0] alu_pack;
  assign alu_pack       = alu_ref(alu_op_out, alu_w_out, file_mem[rf_addr], status_c_out);
  assign alu_result_in  = alu_pack[7:0];
  assign alu_flags_in   = alu_pack[10:8];
  assign alu_c_load_in  = alu_pack[11];
  assign alu_dc_load_in = alu_pack[12];
  assign alu_z_load_in  = alu_pack[13];

  // Instruction-level reference model
  logic [8:0]  m_pc, m_stk0, m_stk1;
  logic [7:0]  m_w;
  logic [2:0]  m_st;
  logic        m_skip, m_sleep;
  logic [7:0]  m_file [32];
  logic [11:0] exp_op;
  logic        exp_we, exp_opt;
  logic [2:0]  exp_tris;
  logic [4:0]  exp_addr;
  logic [7:0]  exp_wdata;
  logic        obs_we, obs_done;
  logic [7:0]  obs_wdata;
  logic [4:0]  obs_addr;
  logic [11:0] obs_op;
  logic [8:0]  obs_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 9'd0; m_stk0 = 9'd0; m_stk1 = 9'd0; m_w = 8'h00; m_st = 3'b000;
    m_skip = 1'b0; m_sleep = 1'b0;
  endtask

  task automatic model_step();
    logic [11:0] ir; logic [13:0] a; logic [7:0] res, fv; logic to_f, to_w; logic [2:0] ns;
    ir = rom[m_pc];
    m_pc = m_pc + 9'd1;
    exp_we = 1'b0; exp_opt = 1'b0; exp_tris = 3'b000; exp_wdata = 8'h00; exp_addr = ir[4:0];
    if (m_skip) begin
      m_skip = 1'b0; exp_op = 12'h000;
      return;
    end
    exp_op = ir;
    fv = m_file[ir[4:0]];
    a = alu_ref(ir, m_w, fv, m_st[0]);
    res = a[7:0]; to_f = 1'b0; to_w = 1'b0;
    casez (ir)
      12'h002: exp_opt = 1'b1;
      12'h003: begin
`ifdef CPU_SLEEP_EN
        m_sleep = 1'b1;
`endif
      end
      12'h005: exp_tris = 3'b001;
      12'h006: exp_tris = 3'b010;
      12'h007: exp_tris = 3'b100;
      12'b0000_000?_????: ;
      12'b0000_001?_????: to_f = 1'b1;
      12'b0000_010?_????: to_w = 1'b1;
      12'b0000_011?_????: to_f = 1'b1;
      12'b00??_????_????: begin
        to_f = ir[5]; to_w = !ir[5];
        if (ir[11:6] == 6'b001011 || ir[11:6] == 6'b001111) m_skip = (res == 8'h00);
      end
      12'b010?_????_????: to_f = 1'b1;
      12'b0110_????_????: m_skip = !fv[ir[7:5]];
      12'b0111_????_????: m_skip = fv[ir[7:5]];
      12'b1000_????_????: begin to_w = 1'b1; m_pc = m_stk0; m_stk0 = m_stk1; end
      12'b1001_????_????: begin m_stk1 = m_stk0; m_stk0 = m_pc; m_pc = {1'b0, ir[7:0]}; end
      12'b101?_????_????: m_pc = ir[8:0];
      default: to_w = 1'b1;
    endcase
    ns = m_st;
    if (to_f && ir[4:0] == 5'h03) ns = res[2:0];
    if (a[11]) ns[0] = a[8];
    if (a[12]) ns[1] = a[9];
    if (a[13]) ns[2] = a[10];
    m_st = ns;
    if (to_f) begin m_file[ir[4:0]] = res; exp_we = 1'b1; exp_wdata = res; end
    if (to_w) m_w = res;
  endtask

  // Runs one instruction; entered and left at the negedge inside Q1
  task automatic run_instr();
    chk("fetch_addr", 32'(prog_addr), 32'(m_pc));
    chk("op_q1", 32'(alu_op_out), 32'h0);
    model_step();
    @(negedge clk);
    @(negedge clk);
    obs_op = alu_op_out;
    chk("alu_op", 32'(alu_op_out), 32'(exp_op));
    @(negedge clk);
    obs_we = rf_we; obs_wdata = rf_wdata; obs_addr = rf_addr; obs_done = instr_done;
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      chk("rf_addr", 32'(rf_addr), 32'(exp_addr));
      chk("rf_wdata", 32'(rf_wdata), 32'(exp_wdata));
    end
    chk("option_we", 32'(option_we), 32'(exp_opt));
    chk("tris_we", 32'(tris_we), 32'(exp_tris));
    chk("instr_done", 32'(instr_done), 32'h1);
    @(negedge clk);
    obs_pc = prog_addr;
    chk("w", 32'(dut.w_q), 32'(m_w));
    chk("status", 32'(dut.status_q), 32'(m_st));
    chk("c_out", 32'(status_c_out), 32'(m_st[0]));
    chk("sleeping", 32'(sleeping), 32'(m_sleep));
    chk("done_low", 32'(instr_done), 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_opt", 32'(option_we), 32'h0);
    chk("rst_tris", 32'(tris_we), 32'h0);
    chk("rst_done", 32'(instr_done), 32'h0);
    chk("rst_sleep", 32'(sleeping), 32'h0);
    chk("rst_pc", 32'(prog_addr), 32'h0);
    chk("rst_w", 32'(alu_w_out), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 12'h000;
  endtask

  function automatic logic [11:0] gen_instr();
    logic [4:0] f; logic [7:0] k; int sel; int m;
    f = 5'($urandom_range(31, 8)); k = 8'($urandom); sel = int'($urandom_range(99, 0));
    if (sel < 35) return {2'b00, 4'($urandom_range(15, 2)), 1'($urandom), f};
    if (sel < 45) return {7'b0000001, ($urandom_range(3, 0) == 0) ? 5'h03 : f};
    if (sel < 50) return {6'b000001, 1'($urandom), f};
    if (sel < 65) return {2'b01, 2'($urandom), 3'($urandom), f};
    if (sel < 80) return {2'b11, 2'($urandom), k};
    if (sel < 85) return {3'b101, 9'($urandom)};
    if (sel < 91) return {4'b1001, k};
    if (sel < 96) return {4'b1000, k};
    m = int'($urandom_range(4, 0));
    case (m)
      0: return 12'h000;
      1: return 12'h002;
      2: return 12'h005;
      3: return 12'h006;
      default: return 12'h007;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_file[i] = 8'h00;
    model_reset();
    clear_rom();
    file_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    file_clr = 1'b0;

    // MOVLW 0x5A ; MOVWF 0x10
    rom[0] = 12'hC5A; rom[1] = 12'h030;
    do_reset();
    run_instr();
    chk("w_5a", 32'(dut.w_q), 32'h5A);
    run_instr();
    chk("movwf_we", 32'(obs_we), 32'h1);
    chk("movwf_addr", 32'(obs_addr), 32'h10);
    chk("movwf_data", 32'(obs_wdata), 32'h5A);
    run_instr();

    // ADDWF 0x10 with W=0xFF, file=0x01
    clear_rom();
    rom[0] = 12'hC01; rom[1] = 12'h030; rom[2] = 12'hCFF; rom[3] = 12'h1F0;
    do_reset();
    repeat (4) run_instr();
    chk("addwf_data", 32'(obs_wdata), 32'h00);
    chk("addwf_flags", 32'(dut.status_q), 32'h7);

    // DECFSZ hits zero and skips MOVLW 0x11
    clear_rom();
    rom[0] = 12'hC01; rom[1] = 12'h030; rom[2] = 12'hC33; rom[3] = 12'h2F0; rom[4] = 12'hC11;
    do_reset();
    repeat (4) run_instr();
    chk("decfsz_data", 32'(obs_wdata), 32'h00);
    run_instr();
    chk("skip_w", 32'(dut.w_q), 32'h33);
    chk("skip_done", 32'(obs_done), 32'h1);
    chk("skip_op", 32'(obs_op), 32'h0);
    run_instr();

    // Two nested calls and returns
    clear_rom();
    rom[0] = 12'h920; rom[9'h020] = 12'h930; rom[9'h030] = 12'h877; rom[9'h021] = 12'h877;
    do_reset();
    repeat (3) run_instr();
    chk("ret1_pc", 32'(obs_pc), 32'h21);
    run_instr();
    chk("ret2_pc", 32'(obs_pc), 32'h01);
    chk("retlw_w", 32'(dut.w_q), 32'h77);

    // Three nested calls overflow the stack
    clear_rom();
    rom[0] = 12'h910; rom[9'h010] = 12'h920; rom[9'h020] = 12'h930;
    rom[9'h030] = 12'h877; rom[9'h021] = 12'h877; rom[9'h011] = 12'h877;
    do_reset();
    repeat (4) run_instr();
    chk("ovf_ret1", 32'(obs_pc), 32'h21);
    run_instr();
    chk("ovf_ret2", 32'(obs_pc), 32'h11);
    run_instr();
    chk("ovf_ret3", 32'(obs_pc), 32'h11);

    // GOTO to the last address, PC wraps
    clear_rom();
    rom[0] = 12'hBFF;
    do_reset();
    run_instr();
    chk("goto_pc", 32'(obs_pc), 32'h1FF);
    run_instr();
    chk("wrap_pc", 32'(obs_pc), 32'h000);

    // Reset in EXECUTE abandons MOVWF 0x11
    clear_rom();
    rom[0] = 12'hC77; rom[1] = 12'h031;
    do_reset();
    run_instr();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_pc", 32'(prog_addr), 32'h0);
    chk("abort_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    chk("abort_we_q4", 32'(rf_we), 32'h0);
    chk("abort_file", 32'(file_mem[5'h11]), 32'(m_file[5'h11]));
    resetn = 1'b1;
    model_reset();
    chk("abort_w", 32'(dut.w_q), 32'h0);
    run_instr();

    // SLEEP
    clear_rom();
    rom[0] = 12'h003; rom[1] = 12'hC42;
    do_reset();
    run_instr();
`ifdef CPU_SLEEP_EN
    for (int i = 0; i < 10; i++) begin
      chk("sleep_flag", 32'(sleeping), 32'h1);
      chk("sleep_addr", 32'(prog_addr), 32'h1);
      @(negedge clk);
    end
    wake_in = 1'b1;
    @(negedge clk);
    wake_in = 1'b0;
    m_sleep = 1'b0;
`else
    chk("nop_sleep_pc", 32'(obs_pc), 32'h1);
    chk("nop_sleep_flag", 32'(sleeping), 32'h0);
`endif
    run_instr();
    chk("after_sleep_w", 32'(dut.w_q), 32'h42);

    // Randomized programs
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 512; i++) rom[i] = gen_instr();
      do_reset();
      for (int n = 0; n < 250; n++) begin
        wake_in = 1'($urandom);
        run_instr();
      end
      wake_in = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_control.md
# cpu_control

Instruction sequencer for the PIC10-compatible CPU. It fetches 12-bit instructions from program memory and drives `cpu_alu` with the opcode and W operand. It consumes the ALU result and flag/load strobes and commits write-back to W, the register file, STATUS and the PC. It owns the PC, the 2-level return stack, W, STATUS C/DC/Z and skip handling; every instruction takes four clocks (Q1–Q4).

## Interface
- `PC_WIDTH`, 9, program-counter and program-address width.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `prog_addr` out PC_WIDTH: program memory address.
- `prog_data` in 12: program memory word; synchronous ROM, one-cycle latency.
- `alu_op_out` out 12: opcode to ALU.
- `alu_w_out` out 8: W register to ALU.
- `status_c_out` out 1: STATUS.C, the ALU carry-in.
- `alu_result_in` in 8: ALU result.
- `alu_flags_in` in 3: ALU flags {Z,DC,C} = bits [2:0].
- `alu_c_load_in`, `alu_dc_load_in`, `alu_z_load_in` in 1: ALU flag-load strobes.
- `rf_addr` out 5: register-file address (IR[4:0]).
- `rf_wdata` out 8: register-file write data.
- `rf_we` out 1: register-file write enable.
- `option_we` out 1: OPTION load strobe.
- `tris_we` out 3: one-hot TRIS strobes for ports 5/6/7.
- `wake_in` in 1: wake request (used only with CPU_SLEEP_EN).
- `sleeping` out 1: core halted.
- `instr_done` out 1: one-cycle pulse in Q4 of each retired or skipped instruction.

## Operation
- States: `FETCH` (Q1) → `DECODE` (Q2) → `EXECUTE` (Q3) → `WRITEBACK` (Q4) → `FETCH`. A `SLEEP` state exists only with the macro.
- **FETCH**: `prog_addr`=PC. At the clock edge, PC ← PC+1, wrapping 0x1FF→0x000.
- **DECODE**: IR ← `prog_data` at the clock edge.
- **EXECUTE/WRITEBACK**: `alu_op_out`=IR, `rf_addr`=IR[4:0]; the ALU path is combinational.
  - In all other states `alu_op_out`=12'h000 (NOP).
  - All commits occur at the WRITEBACK clock edge.
- **Destination**
  - Byte ops with d=IR[5]: d=0 → W, d=1 → file.
  - MOVWF, CLRF, BCF and BSF → file.
  - CLRW and literal ops (MOVLW/ANDLW/IORLW/XORLW/RETLW) → W.
  - OPTION asserts `option_we`; TRIS 5/6/7 assert `tris_we` bit 0/1/2.
  - `rf_wdata`=`alu_result_in`. `rf_we` is high only in WRITEBACK.
- **STATUS**
  - Each bit whose load strobe is high takes the ALU flag.
  - A file write to address 5'h03 writes `alu_result_in[2:0]` into the remaining bits; strobe-loaded bits win.
- **Skips**, decided in WRITEBACK; each sets `skip_q`:
  - DECFSZ/INCFSZ when `alu_flags_in[2]`=1.
  - BTFSC when Z=1.
  - BTFSS when Z=0.
- **Skipped instruction**: the next instruction runs all four states, but `alu_op_out` is forced to NOP and there are no writes or PC redirect. `skip_q` clears at its WRITEBACK.
- **PC redirects** (override the increment):
  - GOTO: PC ← IR[8:0].
  - CALL: PC ← {1'b0, IR[7:0]}; push.
  - RETLW: PC ← stack0; pop.
- **Stack**
  - Push: stack1 ← stack0, stack0 ← PC (already incremented).
  - Pop: stack0 ← stack1; stack1 unchanged.
  - A third push drops the oldest entry; no error flag.

## Timing
- Reset values: state=FETCH, PC=0, IR=0, W=0, C/DC/Z=0, stack=0, `skip_q`=0.
- Output reset values: `rf_we`=0, `option_we`=0, `tris_we`=0, `sleeping`=0, `instr_done`=0.
- Reset is asynchronous at any state. An in-flight instruction is abandoned with no partial write.
- First fetch after reset deassertion: `prog_addr`=0 in cycle 0. IR is valid from cycle 2; write-back occurs at the end of cycle 3.
- Throughput is one instruction per 4 clocks, fixed. No stall on branches; the instruction after a redirect is fetched from the new PC.
- The ALU feedback path has zero latency: flags and result are sampled at the same WRITEBACK edge.

## Configuration
- `CPU_SLEEP_EN` defined:
  - SLEEP (12'h003) in WRITEBACK enters `SLEEP`, with `sleeping`=1 and no fetches.
  - `wake_in`=1 in `SLEEP` returns the core to FETCH on the next edge, with the PC already pointing past SLEEP.
- `CPU_SLEEP_EN` undefined: SLEEP is a NOP, `SLEEP` state is absent, `wake_in` is ignored, `sleeping` is tied 0.

## Test plan
- Reset, then ROM[0]=0xC5A (MOVLW), ROM[1]=0x030 (MOVWF 0x10):
  - W=0x5A after clock 3.
  - `rf_we`=1, `rf_addr`=0x10, `rf_wdata`=0x5A in clock 7.
  - `prog_addr` sequence 0,1,2.
- W=0xFF, file 0x10=0x01, ADDWF 0x1F0 → `rf_wdata`=0x00, C=DC=Z=1.
- DECFSZ 0x2F0 with file 0x10=0x01 → write 0x00, skip. Next MOVLW 0xC11 leaves W unchanged and `instr_done` still pulses.
- CALL 0x920 from addr 0 and from 0x20, then RETLW 0x877 twice:
  - PC returns 0x21 then 0x01.
  - W=0x77.
  - Third nested CALL plus three RETLW → last two returns are equal.
- GOTO 0xBFF, ROM[0x1FF]=NOP → next `prog_addr`=0x000; resetn pulsed low in EXECUTE → no `rf_we`, PC=0.
- With `CPU_SLEEP_EN`: SLEEP → `sleeping`=1 and `prog_addr` frozen for 10 clocks; `wake_in` → fetch resumes at SLEEP+1. Without the macro: 4-clock NOP.
